// File: rtl/w25q_page_reader.sv
// SPI mode-0 read-back engine for W25Q flash: issues READ DATA with a 24-bit
// address, shifts in a page and counts mismatches against the page pattern.
module w25q_page_reader #(
  parameter int          CLK_DIV  = 4,
  parameter int          BYTE_NUM = 256,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [23:0] addr,
  output logic [9:0]  exp_idx,
  input  logic [7:0]  exp_data,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic [10:0] err_cnt,
  output logic        pass
);

  localparam int              DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      LastIdx = 10'(BYTE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT_CA,
    SHIFT_DATA,
    CS_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [DivW-1:0]  r_div;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_csN;
  logic [31:0]      r_caShift;
  logic [4:0]       r_caCnt;
  logic [2:0]       r_bitCnt;
  logic [6:0]       r_shiftIn;
  logic [7:0]       r_rdData;
  logic             r_rdValid;
  logic             r_busy;
  logic             r_done;
  logic [10:0]      r_errCnt;
  logic             r_pass;
  logic [9:0]       r_expIdx;
  logic             r_lastByte;
  logic             w_divEnd;
  logic             w_rise;
  logic             w_fall;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // SCLK edges happen when the half-period divider wraps during a shift state.
  always_comb begin
    w_nextState = r_state;
    w_divEnd    = (r_div == DivLast);
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    if ((r_state == SHIFT_CA) || (r_state == SHIFT_DATA)) begin
      w_rise = w_divEnd && !r_sclk;
      w_fall = w_divEnd && r_sclk;
    end
    case (r_state)
      IDLE:       if (start) w_nextState = CS_SETUP;
      CS_SETUP:   if (w_divEnd) w_nextState = SHIFT_CA;
      SHIFT_CA:   if (w_fall && (r_caCnt == 5'd31)) w_nextState = SHIFT_DATA;
      SHIFT_DATA: if (w_fall && r_lastByte) w_nextState = CS_HOLD;
      CS_HOLD:    if (w_divEnd) w_nextState = IDLE;
      default:    w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_div      <= '0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_csN      <= 1'b1;
      r_caShift  <= '0;
      r_caCnt    <= '0;
      r_bitCnt   <= '0;
      r_shiftIn  <= '0;
      r_rdData   <= '0;
      r_rdValid  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_errCnt   <= '0;
      r_pass     <= 1'b0;
      r_expIdx   <= '0;
      r_lastByte <= 1'b0;
    end else begin
      r_rdValid <= 1'b0;
      r_done    <= 1'b0;
      if ((r_state == IDLE) || w_divEnd) r_div <= '0;
      else                               r_div <= r_div + DivW'(1);
      if (w_rise)      r_sclk <= 1'b1;
      else if (w_fall) r_sclk <= 1'b0;
      // The strobe cycle compares against the pattern byte for the still-current index.
      if (r_rdValid) begin
        r_expIdx <= r_expIdx + 10'd1;
        if (r_rdData != exp_data) r_errCnt <= r_errCnt + 11'd1;
        if (r_expIdx == LastIdx) r_lastByte <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy     <= 1'b1;
            r_csN      <= 1'b0;
            r_mosi     <= READ_CMD[7];
            r_caShift  <= {READ_CMD[6:0], addr, 1'b0};
            r_caCnt    <= '0;
            r_bitCnt   <= '0;
            r_errCnt   <= '0;
            r_pass     <= 1'b0;
            r_expIdx   <= '0;
            r_lastByte <= 1'b0;
          end
        end
        SHIFT_CA: begin
          if (w_fall) begin
            r_mosi    <= r_caShift[31];
            r_caShift <= {r_caShift[30:0], 1'b0};
            r_caCnt   <= r_caCnt + 5'd1;
          end
        end
        SHIFT_DATA: begin
          if (w_rise) begin
            r_shiftIn <= {r_shiftIn[5:0], spi_miso};
            r_bitCnt  <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              r_rdData  <= {r_shiftIn, spi_miso};
              r_rdValid <= 1'b1;
            end
          end
        end
        CS_HOLD: begin
          if (w_divEnd) begin
            r_csN  <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (r_errCnt == 11'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign exp_idx  = r_expIdx;
  assign spi_cs_n = r_csN;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
  assign rd_data  = r_rdData;
  assign rd_valid = r_rdValid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err_cnt  = r_errCnt;
  assign pass     = r_pass;

endmodule

// File: tb/tb_w25q_page_reader.sv
// Bench for w25q_page_reader: behavioural flash slave, pattern source and a
// byte scoreboard filled at each start and drained on every rd_valid strobe.
`timescale 1ns/1ps
module tb_w25q_page_reader;

  localparam int ClkDiv  = 4;
  localparam int ByteNum = 256;
  localparam int BusyLen = ClkDiv + (32 + 8*ByteNum)*2*ClkDiv + ClkDiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] addr;
  logic [9:0]  expIdx;
  logic [7:0]  expData;
  logic        csN;
  logic        sclk;
  logic        mosi;
  logic        miso = 1'b0;
  logic [7:0]  rdData;
  logic        rdValid;
  logic        busy;
  logic        done;
  logic [10:0] errCnt;
  logic        pass;

  int         checkCnt = 0;
  int         passCnt  = 0;
  int         failCnt  = 0;
  logic [7:0] expQ[$];
  int         idxQ[$];
  bit         corruptMode = 1'b0;
  int         expErr;
  int         busyLen;
  int         strobeCnt;
  int         doneCnt;
  int         rise0;
  int         rise1;
  bit         aborted;
  int         flBitCnt = 0;
  logic [31:0] caShift = '0;
  logic [7:0] flByte;
  int         flBit;

  w25q_page_reader #(
    .CLK_DIV (ClkDiv),
    .BYTE_NUM(ByteNum),
    .READ_CMD(8'h03)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .start   (start),
    .addr    (addr),
    .exp_idx (expIdx),
    .exp_data(expData),
    .spi_cs_n(csN),
    .spi_sclk(sclk),
    .spi_mosi(mosi),
    .spi_miso(miso),
    .rd_data (rdData),
    .rd_valid(rdValid),
    .busy    (busy),
    .done    (done),
    .err_cnt (errCnt),
    .pass    (pass)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] patByte(input int i);
    case (i % 10)
      0: return 8'h11;
      1: return 8'h22;
      2: return 8'h33;
      3: return 8'h44;
      4: return 8'h55;
      5: return 8'h66;
      6: return 8'h77;
      7: return 8'h88;
      8: return 8'h99;
      default: return 8'h55;
    endcase
  endfunction

  function automatic logic [7:0] flashByte(input int i);
    if (corruptMode && (i == 5))   return 8'h00;
    if (corruptMode && (i == 255)) return 8'hFF;
    return patByte(i);
  endfunction

  assign expData = patByte(int'(expIdx));

  // Flash slave: capture command/address on SCLK rise, present data after each fall.
  always @(posedge sclk or negedge csN) begin
    if (!csN && sclk) begin
      if (flBitCnt < 32) caShift = {caShift[30:0], mosi};
      flBitCnt = flBitCnt + 1;
    end else if (!csN) begin
      flBitCnt = 0;
    end
  end

  always @(negedge sclk) begin
    if (!csN && (flBitCnt >= 32)) begin
      flBit  = flBitCnt - 32;
      flByte = flashByte(flBit / 8);
      miso   = flByte[7 - (flBit % 8)];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] a);
    start     = 1'b1;
    addr      = a;
    expErr    = 0;
    for (int i = 0; i < ByteNum; i++) begin
      expQ.push_back(flashByte(i));
      idxQ.push_back(i);
      if (flashByte(i) != patByte(i)) expErr++;
    end
    strobeCnt = 0;
    doneCnt   = 0;
    rise0     = -1;
    rise1     = -1;
    @(negedge clk);
    start   = 1'b0;
    busyLen = int'(busy);
    checkOutput("startBusy", 32'(busy), 32'd1);
    checkOutput("startCsN", 32'(csN), 32'd0);
  endtask

  task automatic monitorTransaction(input int abuseAt, input bit startAtDone, input int resetAtByte);
    bit         prevSclk;
    int         sinceStrobe;
    logic [7:0] eByte;
    int         eIdx;
    prevSclk    = sclk;
    sinceStrobe = 0;
    aborted     = 1'b0;
    for (int cyc = 0; cyc < BusyLen + 64; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busyLen++;
      if (sclk && !prevSclk) begin
        if (rise0 < 0)      rise0 = busyLen;
        else if (rise1 < 0) rise1 = busyLen;
      end
      prevSclk = sclk;
      sinceStrobe++;
      if (rdValid) begin
        sinceStrobe = 0;
        strobeCnt++;
        checkOutput("sbDepth", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
          eByte = expQ.pop_front();
          eIdx  = idxQ.pop_front();
          checkOutput("rdData", 32'(rdData), 32'(eByte));
          checkOutput("expIdx", 32'(expIdx), 32'(eIdx));
        end
      end
      if (done) begin
        doneCnt++;
        return;
      end
      if (cyc == abuseAt) begin
        start = 1'b1;
        addr  = 24'hABCDEF;
      end
      if (startAtDone && (busyLen == BusyLen)) start = 1'b1;
      if ((resetAtByte >= 0) && (strobeCnt == resetAtByte) && (sinceStrobe == 20)) begin
        rst     = 1'b1;
        aborted = 1'b1;
        return;
      end
    end
    checkOutput("doneInBudget", 32'(doneCnt), 32'd1);
  endtask

  task automatic checkTransaction(input logic [23:0] a);
    checkOutput("doneBusy", 32'(busy), 32'd0);
    checkOutput("doneCsN", 32'(csN), 32'd1);
    checkOutput("busyLen", 32'(busyLen), 32'(BusyLen));
    checkOutput("strobeCnt", 32'(strobeCnt), 32'(ByteNum));
    checkOutput("sbDrained", 32'(expQ.size()), 32'd0);
    checkOutput("sclkPeriod", 32'(rise1 - rise0), 32'(2*ClkDiv));
    checkOutput("cmdAddr", caShift, {8'h03, a});
    checkOutput("errCnt", 32'(errCnt), 32'(expErr));
    checkOutput("pass", 32'(pass), 32'(expErr == 0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    addr  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstCsN", 32'(csN), 32'd1);
    checkOutput("rstSclk", 32'(sclk), 32'd0);
    checkOutput("rstMosi", 32'(mosi), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstValid", 32'(rdValid), 32'd0);
    checkOutput("rstData", 32'(rdData), 32'd0);
    checkOutput("rstErr", 32'(errCnt), 32'd0);
    checkOutput("rstPass", 32'(pass), 32'd0);
    checkOutput("rstIdx", 32'(expIdx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] clean read-back at 0x001234");
    corruptMode = 1'b0;
    applyStimulus(24'h001234);
    monitorTransaction(-1, 1'b0, -1);
    checkTransaction(24'h001234);
    @(negedge clk);
    checkOutput("donePulseWidth", 32'(done), 32'd0);
    checkOutput("holdData", 32'(rdData), 32'h66);
    checkOutput("holdErr", 32'(errCnt), 32'd0);
    checkOutput("holdPass", 32'(pass), 32'd1);
    checkOutput("idleBusy", 32'(busy), 32'd0);

    $display("[TB] corrupted read-back with start abuse");
    corruptMode = 1'b1;
    applyStimulus(24'h000100);
    monitorTransaction(100, 1'b1, -1);
    checkTransaction(24'h000100);

    $display("[TB] restart after done, reset during byte 100");
    applyStimulus(24'h00ABCD);
    monitorTransaction(-1, 1'b0, 100);
    checkOutput("resetReached", 32'(aborted), 32'd1);
    checkOutput("errBeforeRst", 32'(errCnt), 32'd1);
    @(negedge clk);
    checkOutput("midRstCsN", 32'(csN), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstSclk", 32'(sclk), 32'd0);
    checkOutput("midRstMosi", 32'(mosi), 32'd0);
    checkOutput("midRstValid", 32'(rdValid), 32'd0);
    checkOutput("midRstErr", 32'(errCnt), 32'd0);
    checkOutput("midRstIdx", 32'(expIdx), 32'd0);
    doneCnt = int'(done);
    repeat (2) begin
      @(negedge clk);
      doneCnt += int'(done);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      doneCnt += int'(done);
    end
    checkOutput("midRstNoDone", 32'(doneCnt), 32'd0);
    checkOutput("midRstIdle", 32'(busy), 32'd0);
    expQ.delete();
    idxQ.delete();

    $display("[TB] full page after reset");
    corruptMode = 1'b0;
    applyStimulus(24'hFFFF00);
    monitorTransaction(-1, 1'b0, -1);
    checkTransaction(24'hFFFF00);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/w25q_page_reader.md
Name: w25q_page_reader

Overview:
SPI master read-back engine for the W25Q flash. It issues READ DATA (0x03) with a 24-bit address and shifts in BYTE_NUM bytes on MISO. Each received byte is compared against the expected page pattern, which is fetched through a 10-bit byte index from the same pattern source the page-program path uses. The block sits beside the page-program controller and provides write/read-back verification with a mismatch count and a pass flag.

Parameters:
CLK_DIV, 4, sys_clk cycles per SCLK half-period (>=2)
BYTE_NUM, 256, bytes read per transaction (1..1024)
READ_CMD, 8'h03, flash read opcode

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; accepted only when busy=0
addr  in  24  flash start address, latched on accepted start
exp_idx  out  10  index of the byte currently being received, to the pattern source
exp_data  in  8  expected byte for exp_idx, combinational from the pattern source
spi_cs_n  out  1  flash chip select, active low
spi_sclk  out  1  SPI clock, mode 0
spi_mosi  out  1  command/address serial out
spi_miso  in  1  flash serial data in
rd_data  out  8  last received byte
rd_valid  out  1  one-cycle strobe, rd_data new
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at transaction end
err_cnt  out  11  mismatch count for the current/last transaction
pass  out  1  1 = last transaction completed with err_cnt==0

Behaviour:
- Reset values:
  - spi_cs_n=1; spi_sclk=0; spi_mosi=0.
  - rd_data=0; rd_valid=0; busy=0; done=0; err_cnt=0; pass=0; exp_idx=0.
  - FSM goes to IDLE.
- Reset asserted mid-transaction: all of the above take effect on that edge. No byte strobe, no done pulse.
- SPI mode 0:
  - SCLK idles low.
  - MOSI changes only while SCLK is low.
  - MISO is sampled on the sys_clk edge that drives SCLK 0->1.
  - SCLK period = 2*CLK_DIV sys_clk cycles.
- IDLE:
  - busy=0.
  - start=1 latches addr, clears err_cnt, pass and exp_idx, sets busy=1, and goes to CS_SETUP.
- CS_SETUP: spi_cs_n=0 and SCLK low for CLK_DIV cycles, then go to SHIFT_CA.
- SHIFT_CA:
  - Sends 32 bits MSB first: READ_CMD, then addr[23:16], addr[15:8], addr[7:0].
  - The first bit is valid on MOSI when CS_SETUP is entered.
  - Each later bit is driven on the SCLK falling edge.
- SHIFT_DATA:
  - BYTE_NUM*8 SCLK pulses; MOSI held 0.
  - Bits are shifted in MSB first.
  - On the 8th rising sample of each byte:
    - rd_data is updated and rd_valid pulses for exactly one cycle.
    - In that same cycle, exp_idx still holds that byte's index and rd_data is compared with exp_data.
    - Mismatch increments err_cnt (11 bits, never overflows for BYTE_NUM<=1024).
  - exp_idx increments on the cycle after rd_valid.
  - After the last byte: SCLK stays low, then go to CS_HOLD.
- CS_HOLD:
  - spi_cs_n stays 0 for CLK_DIV cycles, then is driven 1.
  - On that same edge, done pulses 1 for one cycle.
  - busy drops, pass is set to (err_cnt==0), and the FSM returns to IDLE.
  - The final comparison is included in pass.
- Total busy length = CLK_DIV + (32 + 8*BYTE_NUM)*2*CLK_DIV + CLK_DIV cycles.
- start while busy=1 is ignored, including a start in the same cycle as done.
- start is accepted on the cycle after done.
- rd_data, err_cnt and pass hold their values until the next accepted start or reset.
- Address wrap past 0xFFFFFF is the flash's responsibility; the block does no address arithmetic.

Test Plan:
- Reset check: hold sys_rst 3 cycles -> spi_cs_n=1, spi_sclk=0, busy=0, err_cnt=0, pass=0, exp_idx=0.
- Framing: start with addr=24'h001234, CLK_DIV=4 -> first 32 MOSI bits at SCLK rise are 0x03,0x00,0x12,0x34; SCLK period 8 cycles; busy length 8+(32+2048)*8 = 16648 cycles.
- Clean read-back: flash model returns the pattern 11,22,33,44,55,66,77,88,99,55 repeating (index 255 = 0x66), with exp_data from the same pattern -> 256 rd_valid pulses, exp_idx 0..255 at each strobe, done once, err_cnt=0, pass=1.
- Corrupted bytes: model returns 0x00 at index 5 and 0xFF at index 255 -> err_cnt=2, pass=0.
- Protocol abuse: start pulsed mid-transaction and on the done cycle -> ignored, no restart; start on the next cycle -> new transaction begins.
- Reset mid-data: sys_rst during byte 100 -> spi_cs_n=1 and busy=0 after that edge, no done pulse; the next start reads a full page from index 0.
